dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 256x16 data memory between the CPU load/store stage and the debug read port (`rd`/`raddr`/`rdata`) exposed at `top`. The CPU has priority. A bounded starvation counter guarantees that a pending debug read is served within `MAX_WAIT` cycles even under continuous CPU traffic. Sits between the CPU memory stage, the debug port and the synchronous-read data RAM inside `top`.

## Interface
- `AW`, 8, memory address width
- `DW`, 16, memory data width
- `MAX_WAIT`, 4, maximum cycles a pending debug read may be blocked by the CPU before it is forced (1..15)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `int_rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request, level, held until granted
- `cpu_we`  in  1  1 = write, 0 = read; qualified by `cpu_req`
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  combinational; access accepted this cycle
- `cpu_rvalid`  out  1  registered; read data valid, one-cycle pulse
- `cpu_rdata`  out  DW  CPU read data; valid only with `cpu_rvalid`
- `rd`  in  1  debug read strobe, one-cycle pulse
- `raddr`  in  AW  debug read address, sampled with `rd`
- `dbg_busy`  out  1  registered; a debug read is pending, so `rd` is ignored
- `rdata`  out  DW  debug read data; held until the next debug completion
- `dbg_rvalid`  out  1  registered; `rdata` updated this cycle, one-cycle pulse
- `mem_en`, `mem_we`  out  1  RAM command strobes
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  DW  RAM write data
- `mem_rdata`  in  DW  RAM read data, one cycle after `mem_en && !mem_we`

## Operation
- Debug FSM has two states:
  - **D_IDLE**: on `rd`, capture `raddr` into `dbg_addr_q`, clear `wait_cnt`, go to D_PEND.
  - **D_PEND**: `dbg_busy` = 1. Go back to D_IDLE in the cycle the debug read issues to memory.
- Debug wins a cycle when in D_PEND and either `cpu_req` = 0 or `wait_cnt` == `MAX_WAIT`. Otherwise the CPU wins whenever `cpu_req` = 1.
- `cpu_gnt` = `cpu_req` && !debug_wins.
- Memory command in the cycle of a grant:
  - CPU grant: `mem_en` = 1, `mem_we` = `cpu_we`, `mem_addr` = `cpu_addr`, `mem_wdata` = `cpu_wdata`.
  - Debug grant: `mem_en` = 1, `mem_we` = 0, `mem_addr` = `dbg_addr_q`.
  - No grant: `mem_en` = 0.
- `wait_cnt` (4 bit):
  - Increments each cycle in D_PEND while the CPU wins.
  - Saturates at `MAX_WAIT`.
  - Cleared when the debug read issues.
- Response tag register `resp_own` ∈ {NONE, CPU, DBG} records the owner of an issued read. Writes record NONE.
- On the cycle after a read issues:
  - Tag CPU: `cpu_rvalid` = 1, `cpu_rdata` = `mem_rdata`.
  - Tag DBG: `dbg_rvalid` = 1, `rdata` register loads `mem_rdata`.
- `rd` while `dbg_busy` = 1, including the issue cycle, is dropped silently. It does not overwrite `dbg_addr_q`.
- `rd` in D_IDLE coinciding with a CPU request: the capture happens, and the CPU is granted that cycle.
- Reset values:
  - FSM = D_IDLE, `wait_cnt` = 0, `resp_own` = NONE.
  - `dbg_busy`, `cpu_rvalid`, `dbg_rvalid` = 0.
  - `cpu_rdata` = 0, `rdata` = 0, `dbg_addr_q` = 0.
  - The `mem_*` outputs are combinational and are 0 while `int_rst` = 1.
  - `cpu_gnt` = 0 while `int_rst` = 1.
- Reset mid-operation: an issued-but-unreturned read produces no `*_rvalid` pulse, and the pending debug request is discarded.

## Timing
- CPU read: `cpu_req` and `cpu_gnt` at cycle t, `cpu_rvalid` at t+1. Back-to-back reads give one per cycle.
- CPU write: completes at the grant edge. No response pulse.
- Debug read with no CPU traffic: `rd` at t, issue at t+1, `dbg_rvalid` at t+2.
- Debug read under continuous CPU requests: the CPU is granted at t+1 .. t+MAX_WAIT, the debug read issues at t+1+MAX_WAIT, and `dbg_rvalid` follows one cycle later. During the forced cycle `cpu_gnt` = 0 and the CPU holds its request.
- Next debug capture is possible at the earliest one cycle after issue, so the debug throughput is one read per 2 cycles.

## Structure
- Shared defines header `mips_defs.vh` holds:
  - `DMEM_AW` = 8 and `DMEM_DW` = 16
  - `resp_own` encoding: NONE = 2'b00, CPU = 2'b01, DBG = 2'b10
  - Debug FSM state encoding: D_IDLE = 1'b0, D_PEND = 1'b1
- One natural sub-module: `starve_cnt`, a saturating counter with inputs `clr`, `inc` and output `at_max`, parameterised by `MAX_WAIT`.
- The RAM stays outside this block.

## Test plan
- Reset: hold `int_rst` = 1 for 3 cycles with `cpu_req` = 1 and `rd` = 1 → `cpu_gnt` = 0, `mem_en` = 0, `dbg_busy` = 0, both rvalids = 0, `rdata` = 0.
- CPU write then read: write 0xBEEF at 0x12, then read 0x12 → `cpu_gnt` = 1 on both requests, and `cpu_rvalid` = 1 with `cpu_rdata` = 0xBEEF exactly one cycle after the read grant.
- Idle debug read: RAM[0x40] = 0x1234, `rd` pulse with `raddr` = 0x40 at t → `mem_addr` = 0x40 at t+1, then `dbg_rvalid` = 1 and `rdata` = 0x1234 at t+2. `rdata` holds 0x1234 afterwards.
- Starvation: `cpu_req` = 1 every cycle, `MAX_WAIT` = 4, `rd` at t → CPU granted at t+1..t+4, `cpu_gnt` = 0 and debug issued at t+5, `dbg_rvalid` at t+6, and the CPU granted again at t+6.
- Dropped strobe: `rd` at t (addr 0x01), then `rd` at t+1 (addr 0x02) while busy → only one `dbg_rvalid`, carrying RAM[0x01].
- Reset mid-read: debug issued at t, `int_rst` = 1 at t+1 → no `dbg_rvalid`, and `rdata` = 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter.
// Response owner tags and debug FSM states.
package dmem_arbiter_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } resp_own_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_PEND = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating starvation counter for a pending debug read.
// Counts cycles lost to the CPU; at_max forces the debug grant.
module starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [3:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == 4'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU priority, debug reads
// guaranteed service within MAX_WAIT blocked cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          int_rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          rd,
  input  logic [AW-1:0] raddr,
  output logic          dbg_busy,
  output logic [DW-1:0] rdata,
  output logic          dbg_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  dbg_state_e    state_q, state_d;
  resp_own_e     own_q, own_d;
  logic [AW-1:0] dbg_addr_q, dbg_addr_d;
  logic [DW-1:0] rdata_q;
  logic          at_max;
  logic          debug_wins;
  logic          capture;

  assign debug_wins = !int_rst && (state_q == D_PEND)
                      && (!cpu_req || at_max);
  assign cpu_gnt    = !int_rst && cpu_req && !debug_wins;
  assign capture    = !int_rst && (state_q == D_IDLE) && rd;
  assign dbg_busy   = (state_q == D_PEND);

  starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst   (int_rst),
    .clr   (capture || debug_wins),
    .inc   ((state_q == D_PEND) && cpu_gnt),
    .at_max(at_max)
  );

  always_comb begin
    state_d    = state_q;
    dbg_addr_d = dbg_addr_q;
    own_d      = OWN_NONE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (capture) begin
      state_d    = D_PEND;
      dbg_addr_d = raddr;
    end
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      own_d     = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (debug_wins) begin
      mem_en   = 1'b1;
      mem_addr = dbg_addr_q;
      own_d    = OWN_DBG;
      state_d  = D_IDLE;
    end
  end

  // Gated by reset so an in-flight read dies silently.
  assign cpu_rvalid = !int_rst && (own_q == OWN_CPU);
  assign dbg_rvalid = !int_rst && (own_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign rdata      = dbg_rvalid ? mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (int_rst) begin
      state_q    <= D_IDLE;
      own_q      <= OWN_NONE;
      dbg_addr_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      dbg_addr_q <= dbg_addr_d;
      if (dbg_rvalid)
        rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, response scoreboards,
// one task per scenario.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        int_rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        rd;
  logic [7:0]  raddr;
  logic        dbg_busy;
  logic [15:0] rdata;
  logic        dbg_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] ram [256];
  logic [15:0] cpu_exp[$];
  logic [15:0] dbg_exp[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(8), .DW(16), .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .int_rst   (int_rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .rd        (rd),
    .raddr     (raddr),
    .dbg_busy  (dbg_busy),
    .rdata     (rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we)
        ram[mem_addr] <= mem_wdata;
      else
        mem_rdata <= ram[mem_addr];
    end
  end

  // Response scoreboards: pop on every rvalid pulse.
  always @(negedge clk) begin
    logic [15:0] e;
    if (cpu_rvalid === 1'b1) begin
      checks++;
      if (cpu_exp.size() == 0) begin
        failures++;
        $display("FAIL cpu_unexpected_rvalid got=%h", cpu_rdata);
      end else begin
        e = cpu_exp.pop_front();
        if (cpu_rdata !== e) begin
          failures++;
          $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, e);
        end
      end
    end
    if (dbg_rvalid === 1'b1) begin
      checks++;
      if (dbg_exp.size() == 0) begin
        failures++;
        $display("FAIL dbg_unexpected_rvalid got=%h", rdata);
      end else begin
        e = dbg_exp.pop_front();
        if (rdata !== e) begin
          failures++;
          $display("FAIL dbg_rdata got=%h exp=%h", rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a,
                           input logic [15:0] d);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    step();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    int_rst = 1'b1;
    cpu_req = 1'b1;
    rd      = 1'b1;
    raddr   = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_gnt !== 1'b0 || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_gnt_en cyc=%0d gnt=%b en=%b exp=0/0",
                 i, cpu_gnt, mem_en);
      end
      if (i == 2) begin
        checks++;
        if (dbg_busy !== 1'b0 || cpu_rvalid !== 1'b0
            || dbg_rvalid !== 1'b0 || rdata !== 16'h0) begin
          failures++;
          $display("FAIL reset_regs busy=%b crv=%b drv=%b rdata=%h exp=0",
                   dbg_busy, cpu_rvalid, dbg_rvalid, rdata);
        end
      end
      step();
    end
    int_rst = 1'b0;
    cpu_req = 1'b0;
    rd      = 1'b0;
    step();
  endtask

  task automatic test_cpu_wr_rd();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h12;
    cpu_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL wr_gnt gnt=%b we=%b exp=1/1", cpu_gnt, mem_we);
    end
    step();
    cpu_we = 1'b0;
    cpu_exp.push_back(16'hBEEF);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_gnt gnt=%b rvalid=%b exp=1/0",
               cpu_gnt, cpu_rvalid);
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL rd_latency rvalid=%b exp=1", cpu_rvalid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      cpu_write(8'h20 + 8'(i), 16'hA000 + 16'(i));
    for (int i = 0; i < 3; i++) begin
      cpu_req  = 1'b1;
      cpu_addr = 8'h20 + 8'(i);
      cpu_exp.push_back(16'hA000 + 16'(i));
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (cpu_rvalid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_rvalid i=%0d got=%b exp=1", i, cpu_rvalid);
        end
      end
      step();
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_idle_dbg();
    cpu_write(8'h40, 16'h1234);
    rd    = 1'b1;
    raddr = 8'h40;
    dbg_exp.push_back(16'h1234);
    step();
    rd    = 1'b0;
    raddr = 8'h00;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h40
        || dbg_busy !== 1'b1) begin
      failures++;
      $display("FAIL dbg_issue en=%b we=%b addr=%h busy=%b exp=1/0/40/1",
               mem_en, mem_we, mem_addr, dbg_busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b1 || rdata !== 16'h1234) begin
      failures++;
      $display("FAIL dbg_resp rvalid=%b rdata=%h exp=1/1234",
               dbg_rvalid, rdata);
    end
    step();
    step();
    @(negedge clk);
    checks++;
    if (rdata !== 16'h1234 || dbg_busy !== 1'b0) begin
      failures++;
      $display("FAIL dbg_hold rdata=%h busy=%b exp=1234/0",
               rdata, dbg_busy);
    end
    step();
  endtask

  task automatic test_starve();
    logic exp_gnt;
    cpu_write(8'h10, 16'h0F0F);
    cpu_write(8'h55, 16'h5A5A);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 8'h10;
    rd       = 1'b1;
    raddr    = 8'h55;
    dbg_exp.push_back(16'h5A5A);
    for (int k = 0; k <= 6; k++) begin
      exp_gnt = (k != 5);
      if (exp_gnt)
        cpu_exp.push_back(16'h0F0F);
      @(negedge clk);
      checks++;
      if (cpu_gnt !== exp_gnt) begin
        failures++;
        $display("FAIL starve_gnt t+%0d got=%b exp=%b",
                 k, cpu_gnt, exp_gnt);
      end
      if (k == 5) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h55) begin
          failures++;
          $display("FAIL starve_issue en=%b we=%b addr=%h exp=1/0/55",
                   mem_en, mem_we, mem_addr);
        end
      end
      if (k == 6) begin
        checks++;
        if (dbg_rvalid !== 1'b1) begin
          failures++;
          $display("FAIL starve_rvalid got=%b exp=1", dbg_rvalid);
        end
      end
      step();
      rd = 1'b0;
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_drop();
    cpu_write(8'h01, 16'h1111);
    cpu_write(8'h02, 16'h2222);
    rd    = 1'b1;
    raddr = 8'h01;
    dbg_exp.push_back(16'h1111);
    step();
    raddr = 8'h02;
    @(negedge clk);
    checks++;
    if (dbg_busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_busy got=%b exp=1", dbg_busy);
    end
    step();
    rd = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 16'h1111) begin
      failures++;
      $display("FAIL drop_rdata got=%h exp=1111", rdata);
    end
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (dbg_busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_second_busy got=%b exp=0", dbg_busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    cpu_write(8'h60, 16'h6666);
    rd    = 1'b1;
    raddr = 8'h60;
    step();
    rd = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h60) begin
      failures++;
      $display("FAIL mid_issue en=%b addr=%h exp=1/60", mem_en, mem_addr);
    end
    step();
    int_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rvalid got=%b exp=0", dbg_rvalid);
    end
    step();
    @(negedge clk);
    checks++;
    if (rdata !== 16'h0 || dbg_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rdata rdata=%h busy=%b exp=0/0", rdata, dbg_busy);
    end
    int_rst = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int_rst   = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    rd        = 1'b0;
    raddr     = '0;
    #1;
    test_reset();
    test_cpu_wr_rd();
    test_back_to_back();
    test_idle_dbg();
    test_starve();
    test_drop();
    test_reset_mid();
    checks++;
    if (cpu_exp.size() != 0 || dbg_exp.size() != 0) begin
      failures++;
      $display("FAIL missing_resp cpu_left=%0d dbg_left=%0d exp=0/0",
               cpu_exp.size(), dbg_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
